// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_regfile
//  Purpose  : 8x16 write-back register file with a busy scoreboard that gates
//             issue on RAW/WAW hazards, plus same-cycle write-back bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_rs1,
    input  logic [ADDR_W-1:0]    iss_rs2,
    input  logic                 iss_use_rs1,
    input  logic [ADDR_W-1:0]    iss_rd,
    output logic                 iss_ready,
    output logic [DATA_W-1:0]    r1_data,
    output logic [DATA_W-1:0]    r2_data,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 wb_err
);

    localparam int c_nreg = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [c_nreg];
    logic [c_nreg-1:0] r_busy;
    logic              r_wb_err;

    logic w_clr_rs1, w_clr_rs2, w_clr_rd;
    logic w_raw1, w_raw2, w_waw;
    logic w_byp1, w_byp2;
    logic w_wr_en;

    assign w_wr_en   = wb_valid && (wb_rd != '0);

    assign w_clr_rs1 = wb_valid && (wb_rd == iss_rs1);
    assign w_clr_rs2 = wb_valid && (wb_rd == iss_rs2);
    assign w_clr_rd  = wb_valid && (wb_rd == iss_rd);

    assign w_raw1    = iss_use_rs1 && r_busy[iss_rs1] && !w_clr_rs1;
    assign w_raw2    = r_busy[iss_rs2] && !w_clr_rs2;
    assign w_waw     = r_busy[iss_rd] && !w_clr_rd;
    assign iss_ready = !reset && !w_raw1 && !w_raw2 && !w_waw;

    // R0 is never written, so its array slot stays at the reset value of zero.
    assign w_byp1    = w_clr_rs1 && (iss_rs1 != '0);
    assign w_byp2    = w_clr_rs2 && (iss_rs2 != '0);
    assign r1_data   = w_byp1 ? wb_data : r_regs[iss_rs1];
    assign r2_data   = w_byp2 ? wb_data : r_regs[iss_rs2];

    assign busy      = r_busy;
    assign wb_err    = r_wb_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_nreg; i++) begin
                r_regs[i] <= '0;
            end
            r_busy   <= '0;
            r_wb_err <= 1'b0;
        end else begin
            if (wb_valid) begin
                r_busy[wb_rd] <= 1'b0;
            end
            if (w_wr_en) begin
                r_regs[wb_rd] <= wb_data;
                if (!r_busy[wb_rd]) begin
                    r_wb_err <= 1'b1;
                end
            end
            // Placed after the clear so a new in-flight write wins the same edge.
            if (iss_valid && iss_ready && (iss_rd != '0)) begin
                r_busy[iss_rd] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_regfile
//  Purpose  : Self-checking bench for writeback_regfile (expected-value queue).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        iss_valid;
    logic [2:0]  iss_rs1;
    logic [2:0]  iss_rs2;
    logic        iss_use_rs1;
    logic [2:0]  iss_rd;
    logic        iss_ready;
    logic [15:0] r1_data;
    logic [15:0] r2_data;
    logic [7:0]  busy;
    logic        wb_err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp;

    writeback_regfile #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_use_rs1(iss_use_rs1), .iss_rd(iss_rd),
        .iss_ready(iss_ready), .r1_data(r1_data), .r2_data(r2_data),
        .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        iss_valid = 1'b0; iss_rs1 = 3'd3; iss_rs2 = 3'd5; iss_use_rs1 = 1'b1; iss_rd = '0;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
        tick();
        exp = exp_q.pop_front(); checks++;
        if (16'(busy) !== exp) begin errors++; $display("FAIL reset_busy got=%h exp=%h", busy, exp); end
        exp = exp_q.pop_front(); checks++;
        if (16'(wb_err) !== exp) begin errors++; $display("FAIL reset_wb_err got=%h exp=%h", wb_err, exp); end
        exp = exp_q.pop_front(); checks++;
        if (r1_data !== exp) begin errors++; $display("FAIL reset_r1 got=%h exp=%h", r1_data, exp); end
        exp = exp_q.pop_front(); checks++;
        if (r2_data !== exp) begin errors++; $display("FAIL reset_r2 got=%h exp=%h", r2_data, exp); end
        exp = exp_q.pop_front(); checks++;
        if (16'(iss_ready) !== exp) begin errors++; $display("FAIL reset_ready_in got=%h exp=%h", iss_ready, exp); end
        reset = 1'b0;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(iss_ready) !== exp) begin errors++; $display("FAIL reset_ready_out got=%h exp=%h", iss_ready, exp); end
    endtask

    task automatic test_issue_wb();
        iss_valid = 1'b1; iss_rd = 3'd2; iss_rs1 = 3'd0; iss_rs2 = 3'd0; iss_use_rs1 = 1'b1;
        exp_q.push_back(16'h0004);
        tick();
        iss_valid = 1'b0;
        exp = exp_q.pop_front(); checks++;
        if (16'(busy) !== exp) begin errors++; $display("FAIL issue_busy_set got=%h exp=%h", busy, exp); end
        wb_valid = 1'b1; wb_rd = 3'd2; wb_data = 16'h1234;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h1234); exp_q.push_back(16'h0000);
        tick();
        wb_valid = 1'b0; iss_rs1 = 3'd2;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(busy) !== exp) begin errors++; $display("FAIL issue_busy_clr got=%h exp=%h", busy, exp); end
        exp = exp_q.pop_front(); checks++;
        if (r1_data !== exp) begin errors++; $display("FAIL issue_read_r2 got=%h exp=%h", r1_data, exp); end
        exp = exp_q.pop_front(); checks++;
        if (16'(wb_err) !== exp) begin errors++; $display("FAIL issue_wb_err got=%h exp=%h", wb_err, exp); end
    endtask

    task automatic test_raw_bypass();
        iss_valid = 1'b1; iss_rd = 3'd4;
        tick();
        iss_valid = 1'b0; iss_rs1 = 3'd0; iss_rs2 = 3'd4; iss_rd = 3'd1; iss_use_rs1 = 1'b1;
        exp_q.push_back(16'h0000);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(iss_ready) !== exp) begin errors++; $display("FAIL raw_stall got=%h exp=%h", iss_ready, exp); end
        wb_valid = 1'b1; wb_rd = 3'd4; wb_data = 16'h00AB;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h00AB);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(iss_ready) !== exp) begin errors++; $display("FAIL raw_bypass_ready got=%h exp=%h", iss_ready, exp); end
        exp = exp_q.pop_front(); checks++;
        if (r2_data !== exp) begin errors++; $display("FAIL raw_bypass_data got=%h exp=%h", r2_data, exp); end
        exp_q.push_back(16'h0000); exp_q.push_back(16'h00AB);
        tick();
        wb_valid = 1'b0;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(busy) !== exp) begin errors++; $display("FAIL raw_busy_clr got=%h exp=%h", busy, exp); end
        exp = exp_q.pop_front(); checks++;
        if (r2_data !== exp) begin errors++; $display("FAIL raw_array_data got=%h exp=%h", r2_data, exp); end
    endtask

    task automatic test_immediate();
        iss_valid = 1'b1; iss_rd = 3'd6; iss_rs1 = 3'd0; iss_rs2 = 3'd0;
        exp_q.push_back(16'h0040);
        tick();
        iss_valid = 1'b0;
        exp = exp_q.pop_front(); checks++;
        if (16'(busy) !== exp) begin errors++; $display("FAIL imm_busy got=%h exp=%h", busy, exp); end
        iss_use_rs1 = 1'b0; iss_rs1 = 3'd6; iss_rs2 = 3'd1; iss_rd = 3'd3;
        exp_q.push_back(16'h0001);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(iss_ready) !== exp) begin errors++; $display("FAIL imm_ready got=%h exp=%h", iss_ready, exp); end
        iss_rd = 3'd6;
        exp_q.push_back(16'h0000);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(iss_ready) !== exp) begin errors++; $display("FAIL imm_waw got=%h exp=%h", iss_ready, exp); end
        iss_rd = 3'd3; iss_use_rs1 = 1'b1;
        exp_q.push_back(16'h0000);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(iss_ready) !== exp) begin errors++; $display("FAIL imm_raw1 got=%h exp=%h", iss_ready, exp); end
        wb_valid = 1'b1; wb_rd = 3'd6; wb_data = 16'hC0DE;
        exp_q.push_back(16'h0000);
        tick();
        wb_valid = 1'b0;
        exp = exp_q.pop_front(); checks++;
        if (16'(busy) !== exp) begin errors++; $display("FAIL imm_busy_clr got=%h exp=%h", busy, exp); end
    endtask

    task automatic test_r0_err();
        iss_rs1 = 3'd0; iss_rs2 = 3'd0;
        wb_valid = 1'b1; wb_rd = 3'd0; wb_data = 16'hFFFF;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (r1_data !== exp) begin errors++; $display("FAIL r0_no_bypass got=%h exp=%h", r1_data, exp); end
        tick();
        wb_valid = 1'b0;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (r1_data !== exp) begin errors++; $display("FAIL r0_read got=%h exp=%h", r1_data, exp); end
        exp = exp_q.pop_front(); checks++;
        if (16'(wb_err) !== exp) begin errors++; $display("FAIL r0_wb_err got=%h exp=%h", wb_err, exp); end
        iss_valid = 1'b1; iss_rd = 3'd0;
        exp_q.push_back(16'h0000);
        tick();
        iss_valid = 1'b0;
        exp = exp_q.pop_front(); checks++;
        if (16'(busy) !== exp) begin errors++; $display("FAIL r0_never_busy got=%h exp=%h", busy, exp); end
        wb_valid = 1'b1; wb_rd = 3'd7; wb_data = 16'h5A5A;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h5A5A); exp_q.push_back(16'h0001);
        tick();
        wb_valid = 1'b0; iss_rs1 = 3'd7;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(wb_err) !== exp) begin errors++; $display("FAIL err_set got=%h exp=%h", wb_err, exp); end
        exp = exp_q.pop_front(); checks++;
        if (r1_data !== exp) begin errors++; $display("FAIL err_write_done got=%h exp=%h", r1_data, exp); end
        tick(); tick();
        exp = exp_q.pop_front(); checks++;
        if (16'(wb_err) !== exp) begin errors++; $display("FAIL err_sticky got=%h exp=%h", wb_err, exp); end
    endtask

    task automatic test_setwins_reset();
        iss_valid = 1'b1; iss_rd = 3'd5; iss_rs1 = 3'd0; iss_rs2 = 3'd0; iss_use_rs1 = 1'b1;
        tick();
        wb_valid = 1'b1; wb_rd = 3'd5; wb_data = 16'h1111;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0020); exp_q.push_back(16'h1111);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(iss_ready) !== exp) begin errors++; $display("FAIL setwins_ready got=%h exp=%h", iss_ready, exp); end
        tick();
        wb_valid = 1'b0; iss_valid = 1'b0; iss_rs2 = 3'd5;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(busy) !== exp) begin errors++; $display("FAIL setwins_busy got=%h exp=%h", busy, exp); end
        exp = exp_q.pop_front(); checks++;
        if (r2_data !== exp) begin errors++; $display("FAIL setwins_data got=%h exp=%h", r2_data, exp); end
        reset = 1'b1; wb_valid = 1'b1; wb_rd = 3'd5; wb_data = 16'h0F0F;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        tick();
        reset = 1'b0; wb_valid = 1'b0;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (16'(busy) !== exp) begin errors++; $display("FAIL midrst_busy got=%h exp=%h", busy, exp); end
        exp = exp_q.pop_front(); checks++;
        if (r2_data !== exp) begin errors++; $display("FAIL midrst_r5 got=%h exp=%h", r2_data, exp); end
        exp = exp_q.pop_front(); checks++;
        if (16'(wb_err) !== exp) begin errors++; $display("FAIL midrst_wb_err got=%h exp=%h", wb_err, exp); end
    endtask

    initial begin
        test_reset();
        test_issue_wb();
        test_raw_bypass();
        test_immediate();
        test_r0_err();
        test_setwins_reset();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
Consumer end of the execute-unit result interface. It takes the execute stage's result word and destination address, writes it into an 8 x 16 register file, and returns operand data to execute. A per-register busy scoreboard lets the decoder issue only hazard-free instructions, with same-cycle write-back bypass. It sits between decode/issue and execute and closes the datapath loop.

Parameters:
DATA_W, 16, register and result width (matches the execute data_out width)
ADDR_W, 3, register address width; register count = 2**ADDR_W (8)

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous, active-high reset
wb_valid  input  1  execute result valid this cycle
wb_rd  input  ADDR_W  destination register, driven by execute rd_out
wb_data  input  DATA_W  result word, driven by execute data_out
iss_valid  input  1  decoder presents an instruction for issue
iss_rs1  input  ADDR_W  source register 1 address
iss_rs2  input  ADDR_W  source register 2 address
iss_use_rs1  input  1  0 for immediate-form ops (rs1 not read, no hazard check)
iss_rd  input  ADDR_W  destination register of the issuing instruction
iss_ready  output  1  issue accepted this cycle when iss_valid=1
r1_data  output  DATA_W  operand 1 to execute (combinational read with bypass)
r2_data  output  DATA_W  operand 2 to execute (combinational read with bypass)
busy  output  2**ADDR_W  scoreboard; bit n=1 means a write to Rn is in flight
wb_err  output  1  sticky flag: write-back to a register that was not busy

Behaviour:
- Reset (sync, checked at clk edge): all registers 0, busy=0, wb_err=0.
- While reset=1, iss_ready=0; r1_data/r2_data still reflect the current array contents.
- R0 is hardwired to zero:
  - reads return 0;
  - writes are ignored;
  - R0 is never marked busy;
  - a write-back to R0 never sets wb_err.
- Read path is combinational, zero latency. If wb_valid && wb_rd==rsX && rsX!=0, rX_data=wb_data (bypass). Otherwise rX_data=regs[rsX].
- Write: on the clk edge with wb_valid=1 and wb_rd!=0, regs[wb_rd]<=wb_data. The data is visible through the array from the next cycle and through the bypass in the same cycle.
- Scoreboard clear: a write-back with wb_valid=1 clears busy[wb_rd] at the edge.
- Scoreboard set: an accepted issue (iss_valid && iss_ready) with iss_rd!=0 sets busy[iss_rd] at the edge.
- Same-cycle set and clear of the same register: set wins, so busy stays 1 (a new write is in flight).
- Hazard terms, where "clr_n" means wb_valid && wb_rd==n this cycle:
  - RAW1 = iss_use_rs1 && busy[iss_rs1] && !clr_rs1
  - RAW2 = busy[iss_rs2] && !clr_rs2
  - WAW = busy[iss_rd] && !clr_rd
  - iss_ready = !reset && !RAW1 && !RAW2 && !WAW
  - iss_ready does not depend on iss_valid.
- wb_err: set when wb_valid=1, wb_rd!=0 and busy[wb_rd]=0 at that edge. The write is still performed. The flag is cleared only by reset.
- Reset mid-operation: all in-flight busy bits are dropped. A wb_valid in the same cycle as reset is ignored (no write, no wb_err).
- Simultaneous issue and write-back to different registers are independent and both take effect at the same edge.
- Width rules: no arithmetic is performed. All data paths are DATA_W bits and addresses are ADDR_W bits, used unsigned.

Test Plan:
- Reset then read: assert reset 1 cycle → busy=0, wb_err=0, r1_data=r2_data=0 for rs1=3, rs2=5; iss_ready=0 during reset, 1 after.
- Issue rd=2, then wb_valid wb_rd=2 wb_data=16'h1234 → busy[2]=1 after issue, 0 after write-back; next-cycle read of rs1=2 gives 16'h1234; wb_err=0.
- RAW stall and bypass:
  - busy[4]=1, iss_rs2=4 → iss_ready=0.
  - Same cycle with wb_valid wb_rd=4 wb_data=16'h00AB → iss_ready=1 and r2_data=16'h00AB.
- Immediate form: busy[6]=1, iss_use_rs1=0, iss_rs1=6, iss_rs2=1 (not busy), iss_rd=3 → iss_ready=1. WAW case: iss_rd=6 → iss_ready=0.
- R0 and error cases:
  - wb_valid wb_rd=0 wb_data=16'hFFFF → R0 still reads 0, wb_err=0.
  - wb_valid wb_rd=7 with busy[7]=0 → regs[7] written, wb_err=1 and stays 1 until reset.
- Set-wins and reset mid-flight:
  - Write-back to R5 while issuing rd=5 in the same cycle → busy[5]=1 afterwards.
  - Then assert reset alongside wb_valid wb_rd=5 wb_data=16'h0F0F → busy=0, R5 reads 0, wb_err=0.
